// File: rtl/light_accum_pkg.sv
// Shared types and constants for the light accumulation / resolve block.
// Dither table is only consumed when LIGHT_ACCUM_DITHER_EN is defined.
package light_accum_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  localparam int          PIX_W        = 16;
  localparam logic [14:0] Q115_MAX     = 15'h7FFF;
  localparam int          UNORM8_SHIFT = 7;

  // 2x2 ordered dither, indexed by {px[1], px[0]}
  localparam logic [6:0] DITHER_TBL [4] = '{7'd0, 7'd64, 7'd96, 7'd32};

  typedef struct packed {
    logic [PIX_W-1:0] px;
    logic [23:0]      rgb;
    logic [4:0]       lights;
  } res_pix_t;

endpackage

// File: rtl/light_accum_fifo.sv
// Synchronous show-ahead FIFO for resolved pixels; head entry is always on data_o.
// Push and pop in the same cycle are allowed even when full.
module light_accum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_ok) rptr_d = rptr_q + 1'b1;
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/light_accum_resolve.sv
// Sums per-light Q1.15 RGB beats per pixel, resolves to UNORM8 and queues results.
// Optional ordered dither before quantisation: define LIGHT_ACCUM_DITHER_EN.
module light_accum_resolve
  import light_accum_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PX_W       = 16,
  parameter int ACC_W      = 20,
  parameter int MAX_LIGHTS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [15:0]     in_r,
  input  logic [15:0]     in_g,
  input  logic [15:0]     in_b,
  input  logic [PX_W-1:0] in_px,
  input  logic            in_last,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PX_W-1:0] out_px,
  output logic [23:0]     out_rgb,
  output logic [4:0]      out_lights,
  output logic            ovf_sticky,
  output logic            px_err_sticky
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_r_q, acc_g_q, acc_b_q;
  logic [ACC_W-1:0] acc_r_d, acc_g_d, acc_b_d;
  logic [PX_W-1:0]  cur_px_q, cur_px_d;
  logic [4:0]       count_q, count_d;
  logic             stage_valid_q, stage_valid_d;
  res_pix_t         stage_q, stage_d;
  logic             ovf_q, ovf_d;
  logic             pxerr_q, pxerr_d;

  logic             accept, start;
  logic [ACC_W-1:0] sum_r, sum_g, sum_b;
  logic [14:0]      s_r, s_g, s_b;
  logic [4:0]       count_new;
  logic [23:0]      res_rgb;
  logic [CNT_W-1:0] fifo_count;
  logic [$bits(res_pix_t)-1:0] fifo_data;
  res_pix_t         head;

  function automatic logic [ACC_W-1:0] clamp_in(input logic [15:0] x);
    return x[15] ? '0 : ACC_W'(x[14:0]);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    logic [ACC_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[ACC_W] ? '1 : t[ACC_W-1:0];
  endfunction

  function automatic logic [14:0] sat15(input logic [ACC_W-1:0] a);
    return (a > ACC_W'(Q115_MAX)) ? Q115_MAX : a[14:0];
  endfunction

  assign accept    = in_valid & in_ready;
  assign start     = (state_q == IDLE) || (in_px != cur_px_q);
  assign sum_r     = start ? clamp_in(in_r) : sat_add(acc_r_q, clamp_in(in_r));
  assign sum_g     = start ? clamp_in(in_g) : sat_add(acc_g_q, clamp_in(in_g));
  assign sum_b     = start ? clamp_in(in_b) : sat_add(acc_b_q, clamp_in(in_b));
  assign count_new = start ? 5'd1 : count_q + 5'd1;
  assign s_r       = sat15(sum_r);
  assign s_g       = sat15(sum_g);
  assign s_b       = sat15(sum_b);

`ifdef LIGHT_ACCUM_DITHER_EN
  function automatic logic [7:0] dither_cvt(input logic [14:0] s, input logic [1:0] idx);
    logic [15:0] t;
    t = {1'b0, s} + {9'd0, DITHER_TBL[idx]};
    return t[15] ? 8'hFF : 8'(t >> UNORM8_SHIFT);
  endfunction

  assign res_rgb = {dither_cvt(s_r, in_px[1:0]), dither_cvt(s_g, in_px[1:0]),
                    dither_cvt(s_b, in_px[1:0])};
`else
  assign res_rgb = {8'(s_r >> UNORM8_SHIFT), 8'(s_g >> UNORM8_SHIFT),
                    8'(s_b >> UNORM8_SHIFT)};
`endif

  // Credit check uses only registered state so the lighting core sees a clean ready
  assign in_ready = (32'(fifo_count) + 32'(stage_valid_q)) < 32'(FIFO_DEPTH);

  always_comb begin
    state_d       = state_q;
    acc_r_d       = acc_r_q;
    acc_g_d       = acc_g_q;
    acc_b_d       = acc_b_q;
    cur_px_d      = cur_px_q;
    count_d       = count_q;
    stage_valid_d = 1'b0;
    stage_d       = stage_q;
    ovf_d         = ovf_q | (in_valid & ~in_ready);
    pxerr_d       = pxerr_q;
    if (accept) begin
      if (state_q == ACCUM && in_px != cur_px_q) pxerr_d = 1'b1;
      acc_r_d  = sum_r;
      acc_g_d  = sum_g;
      acc_b_d  = sum_b;
      cur_px_d = in_px;
      count_d  = count_new;
      if (in_last || count_new == 5'(MAX_LIGHTS)) begin
        state_d        = IDLE;
        stage_valid_d  = 1'b1;
        stage_d.px     = in_px;
        stage_d.rgb    = res_rgb;
        stage_d.lights = count_new;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_r_q       <= '0;
      acc_g_q       <= '0;
      acc_b_q       <= '0;
      cur_px_q      <= '0;
      count_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      ovf_q         <= 1'b0;
      pxerr_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_r_q       <= acc_r_d;
      acc_g_q       <= acc_g_d;
      acc_b_q       <= acc_b_d;
      cur_px_q      <= cur_px_d;
      count_q       <= count_d;
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
      ovf_q         <= ovf_d;
      pxerr_q       <= pxerr_d;
    end
  end

  light_accum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(res_pix_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stage_valid_q),
    .data_i  (stage_q),
    .pop_i   (out_ready),
    .data_o  (fifo_data),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign head          = res_pix_t'(fifo_data);
  assign out_px        = out_valid ? head.px     : '0;
  assign out_rgb       = out_valid ? head.rgb    : '0;
  assign out_lights    = out_valid ? head.lights : '0;
  assign ovf_sticky    = ovf_q;
  assign px_err_sticky = pxerr_q;

endmodule

// File: doc/light_accum_resolve.md
# light_accum_resolve

Downstream consumer of the deferred lighting core. Sums the per-light Q1.15 RGB contributions of one pixel across successive light beats, then saturates, converts to UNORM8 and queues the resolved pixel in a small FIFO for the framebuffer writer behind a valid/ready handshake. The lighting core has no backpressure, so this block also reports dropped beats.

## Interface
- FIFO_DEPTH, 4: resolved-pixel FIFO entries (power of two, ≥2)
- PX_W, 16: pixel index width
- ACC_W, 20: per-channel accumulator width (unsigned)
- MAX_LIGHTS, 16: beats per pixel before forced resolve (≤ 2^(ACC_W-15))
- clk  in  1  sole clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  light beat valid (lighting core's valid_out)
- in_r, in_g, in_b  in  16 each  signed Q1.15 contribution
- in_px  in  PX_W  pixel index of beat
- in_last  in  1  final light for this pixel
- in_ready  out  1  beat will be accepted this cycle
- out_valid  out  1  resolved pixel available
- out_ready  in  1  writer accepts
- out_px  out  PX_W  pixel index
- out_rgb  out  24  {r8,g8,b8} UNORM8
- out_lights  out  5  beats summed for this pixel
- ovf_sticky  out  1  a beat arrived with in_ready low; cleared only by reset
- px_err_sticky  out  1  pixel index changed mid-accumulation; cleared only by reset

## Operation
- States: IDLE (no partial pixel), ACCUM (partial sums held).
- Accepted beat = in_valid & in_ready. Negative channel input clamps to 0 before summing.
- IDLE + accepted beat: acc ← clamped input, cur_px ← in_px, count ← 1; if in_last → resolve, stay IDLE; else → ACCUM.
- ACCUM + accepted beat, in_px == cur_px: acc ← acc + input (saturate at 2^ACC_W−1), count+1; resolve on in_last or count reaching MAX_LIGHTS → IDLE.
- ACCUM + accepted beat, in_px ≠ cur_px: set px_err_sticky, discard partial sums, treat beat as IDLE start.
- Resolve: final sum loaded into stage register (stage_valid). Per channel: s = min(acc, 32767); c8 = s >> 7.
- Stage register writes into FIFO on next cycle; FIFO is show-ahead, out_* driven from head entry.
- in_ready = (fifo_count + stage_valid) < FIFO_DEPTH, from registers only; applies to all beats, last or not.
- in_valid & ~in_ready: beat dropped, state unchanged, ovf_sticky ← 1.
- Pop = out_valid & out_ready. Simultaneous push and pop always legal, including full; count unchanged.

## Timing
- Reset (rst_n low at posedge): state IDLE, acc/count/stage/FIFO cleared; out_valid, in_ready's dependants, out_px, out_rgb, out_lights, ovf_sticky, px_err_sticky all 0; in_ready = 1 after reset. Reset mid-pixel discards partial sums and queued pixels.
- Last beat sampled at edge E → stage valid after E → FIFO write at E+1 → out_valid high in cycle after E+1 (latency 2 edges with empty FIFO).
- Back-to-back single-beat pixels sustain one pixel per cycle while out_ready held high.
- out_* stable while out_valid & ~out_ready.

## Configuration
- LIGHT_ACCUM_DITHER_EN defined: before shift, add 2x2 ordered dither d = {0,64,96,32}[{px[0],px[1]}... index {out_px[1],out_px[0]}] to s; result saturates at 255.
- Undefined: plain truncation s >> 7; no dither logic present.

## Structure
- Package light_accum_pkg: state enum (IDLE, ACCUM), Q1.15 max constant 32767, UNORM8 shift 7, dither table, packed resolved-pixel struct {px, rgb, lights}.
- One sub-module: light_accum_fifo (synchronous show-ahead FIFO, depth FIFO_DEPTH, count output).

## Test plan
- Reset: hold rst_n low 3 cycles with in_valid high → all outputs 0, in_ready 1 after release, no FIFO entries.
- Two beats px=5: (8192,0,0) then (8192,16384,40000→clamp path via −1 = 0xFFFF) last → out_rgb {128,128,0}, out_lights 2, out_valid two edges after last.
- Saturation: 4 beats px=9 each r=16384 → r8=255; 20 beats with MAX_LIGHTS=16 → forced resolve at 16, remaining 4 form new pixel.
- Backpressure: out_ready=0, push 5 single-beat pixels (DEPTH 4) → in_ready drops after 4th stage/FIFO fill, 5th beat dropped, ovf_sticky=1; release → 4 pixels drained in order.
- Pixel switch: beat px=3 (not last) then px=4 last → px_err_sticky=1, only px=4 emitted with out_lights 1.
- Dither (macro on): r=1000 at px=0..3 → r8 = 7,8,8,8; macro off → 7 for all.
